hwpe_cmd_sequencer: RTL and testbench
=====================================

Name: hwpe_cmd_sequencer

Overview:
- Synthesisable, parametrised hardware successor to the HWPE test-instruction stream.
- Emits the full HWPE command sequence for one convolution layer: reset, wcfg, wfad×(NUM_FADDR/2), wacc×ROWS×PES, matrix, then per-tile racc or relu drains.
- Sits between the host config registers and the HWPE command port; a ready/valid handshake replaces the file dump.
- New behaviour over the fixed flow:
  - generic ROWS/PES/base-address count;
  - run-time mode select (readacc / relu / accumulate-only);
  - abort;
  - zero-count skip;
  - beat counter.

Parameters:
- ROWS, 8, accumulator rows per PE; 1..8, because the row id is 3 bits.
- PES, 16, PEs per row; 1..32.
- NUM_FADDR, 8, feature base addresses; even, 2..32.
- OPCODE, 7'b0001011, custom-0 opcode placed in every instruction.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; latches all cfg_* inputs; ignored unless busy=0
- abort  in  1  synchronous abort; returns the block to IDLE next cycle
- cfg0  in  32  {Conv_W_offset[15:0], Conv_CH_count[15:0]}
- cfg1  in  32  packed K_count/AccReg_shift/Kernel_333/Layer_type/Data_type/Kernel_size word
- cfg_vrs1  in  32  {W_count[15:0], H_count[15:0]}
- cfg_vrs2  in  32  {W_stride[15:0], H_stride[15:0]}
- cfg_base_addr  in  32*NUM_FADDR  flat base-address array; entry i at bits [32i+31:32i]
- cfg_k_count  in  10  K/16 output-channel tiles
- cfg_mode  in  2  0=readacc, 1=relu, 2=accumulate-only (no drain), 3=reserved (treated as 0)
- cfg_relu_addr  in  32  rs1 value carried by relu commands
- cmd_valid  out  1  command word valid
- cmd_ready  in  1  downstream accepts the word
- cmd_data  out  96  {instr[31:0], rs1_val[31:0], rs2_val[31:0]}
- busy  out  1  high from the cycle after start until return to IDLE
- done  out  1  one-cycle pulse after the last beat is accepted
- beat_cnt  out  32  number of accepted beats in the current run

Behaviour:
- Reset values: cmd_valid=0, cmd_data=0, busy=0, done=0, beat_cnt=0, state=IDLE.
- Instruction encoding: {funct7, rs2, rs1, xd, xs1, xs2, rd, OPCODE}.
  - reset: funct7=64, xd/xs1/xs2=000.
  - wcfg: funct7=2, 011.
  - wfad: funct7=1, 011, rd=addr_idx.
  - matrix: funct7=4, 011.
  - wacc: funct7=8, rs2=pe, 010, rd=row.
  - racc: funct7=16, rs2=pe, rs1=row, 100.
  - relu: funct7=32, rs2=row, 010.
- State sequence: IDLE -> RST -> WCFG -> WFAD -> WACC -> MATRIX -> DRAIN -> FIN -> IDLE.
- Operand values per state:
  - RST: rs1/rs2 = 0.
  - WCFG: rs1=cfg0, rs2=cfg1.
  - WFAD: beat j uses rd=2j, rs1=base[2j], rs2=base[2j+1]; NUM_FADDR/2 beats.
  - WACC: iterates row outer, pe inner; operands 0.
  - MATRIX: rs1=cfg_vrs1, rs2=cfg_vrs2.
- DRAIN loop order: k outer, w, h inner (counts from cfg_k_count, vrs1[31:16], vrs1[15:0]).
  - Per tile, readacc mode issues ROWS×PES racc beats (row outer, pe inner).
  - Per tile, relu mode issues ROWS relu beats with rs1=cfg_relu_addr, rs2=0.
  - Enable marker: in the last beat of a tile that is not the final tile, the accreg id is {2'b10, row[2:0]}. The final tile's last beat uses the plain id.
- Mode 2 and zero-count skip: mode 2, or any of k/w/h count equal to 0, skips DRAIN and goes from MATRIX to FIN.
- Handshake:
  - A beat transfers when cmd_valid && cmd_ready.
  - cmd_data and cmd_valid are registered.
  - While cmd_valid=1 and cmd_ready=0, cmd_data holds stable.
  - cmd_valid never drops without a transfer, except on abort or rst.
  - Back-to-back transfers sustain 1 beat per cycle.
  - First cmd_valid rises 1 cycle after start.
- FIN: drives no command; pulses done=1 for 1 cycle, clears busy, returns to IDLE.
- start while busy is ignored. Config inputs are sampled only on the accepted start.
- abort:
  - Takes priority over a transfer in the same cycle; that beat is not counted.
  - Next cycle: cmd_valid=0, busy=0, no done pulse; beat_cnt holds its value.
- rst mid-run restores all reset values next cycle.
- beat_cnt clears on an accepted start and increments per transfer. It saturates at 0xFFFFFFFF.
- All loop counters are sized to the width of their count field; wrap is compared against count−1.

Decomposition:
- Shared package/header hwpe_cmd_pkg holds:
  - funct7 constants: FN_RESET=64, FN_WCFG=2, FN_WFAD=1, FN_MATRIX=4, FN_WACC=8, FN_RACC=16, FN_RELU=32;
  - the state encoding;
  - MODE_* constants.
- One combinational sub-module, hwpe_instr_enc, builds the 32-bit instruction from (kind, row, pe, rd, en_flag).

Test Plan:
- ROWS=8, PES=16, k=w=h=1, mode 0, cmd_ready=1 -> 263 beats.
  - Beat0 = 8000000B_00000000_00000000; beat1 instr 0400300B; beat2 instr 0200300B; beat3 instr 0200310B.
  - Last beat instr 20F3C00B with no en marker; done pulses once.
- k=1, w=1, h=2, mode 0 -> beat 263 (last of tile 0) instr 20FBC00B; final beat 20F3C00B; total 391.
- Mode 1, h=2 -> tile-0 row-7 beat 4170200B with rs1=cfg_relu_addr; final beat 4070200B; total 151.
- Random cmd_ready stalls (50%) -> cmd_data stable while stalled; beat sequence identical to the no-stall run.
- Mode 2, or w=0 -> MATRIX followed directly by done; total 135 beats.
- abort asserted at beat 40 -> cmd_valid=0 next cycle, busy=0, beat_cnt=40, no done pulse. A fresh start then replays from the reset beat.

Source files
------------

// File: rtl/hwpe_cmd_pkg.sv
// Shared definitions for the HWPE command sequencer: funct7 codes,
// FSM state encoding, command kinds and drain-mode constants.
package hwpe_cmd_pkg;

    localparam logic [6:0] FN_RESET  = 7'd64;
    localparam logic [6:0] FN_WCFG   = 7'd2;
    localparam logic [6:0] FN_WFAD   = 7'd1;
    localparam logic [6:0] FN_MATRIX = 7'd4;
    localparam logic [6:0] FN_WACC   = 7'd8;
    localparam logic [6:0] FN_RACC   = 7'd16;
    localparam logic [6:0] FN_RELU   = 7'd32;

    localparam logic [1:0] MODE_READACC  = 2'd0;
    localparam logic [1:0] MODE_RELU     = 2'd1;
    localparam logic [1:0] MODE_ACC_ONLY = 2'd2;
    localparam logic [1:0] MODE_RESERVED = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST,
        ST_WCFG,
        ST_WFAD,
        ST_WACC,
        ST_MATRIX,
        ST_DRAIN,
        ST_FIN
    } state_e;

    typedef enum logic [2:0] {
        KIND_RESET,
        KIND_WCFG,
        KIND_WFAD,
        KIND_MATRIX,
        KIND_WACC,
        KIND_RACC,
        KIND_RELU
    } cmd_kind_e;

    // Accumulator register id; the top bits flag "enable next tile".
    function automatic logic [4:0] accreg_id(input logic [2:0] row, input logic en_flag);
        return {en_flag, 1'b0, row};
    endfunction

endpackage

// File: rtl/hwpe_instr_enc.sv
// Combinational builder for one 32-bit HWPE custom instruction:
// {funct7, rs2, rs1, xd, xs1, xs2, rd, opcode}.
module hwpe_instr_enc
    import hwpe_cmd_pkg::*;
#(
    parameter logic [6:0] OPCODE = 7'b0001011
) (
    input  cmd_kind_e   kind,
    input  logic [2:0]  row,
    input  logic [4:0]  pe,
    input  logic [4:0]  rd,
    input  logic        en_flag,
    output logic [31:0] instr
);

    logic [6:0] funct7;
    logic [4:0] rs2_f;
    logic [4:0] rs1_f;
    logic [2:0] xflags;
    logic [4:0] rd_f;

    // Select the field values for each command kind.
    always_comb begin
        funct7 = '0;
        rs2_f  = '0;
        rs1_f  = '0;
        xflags = '0;
        rd_f   = '0;
        case (kind)
            KIND_RESET: begin
                funct7 = FN_RESET;
            end
            KIND_WCFG: begin
                funct7 = FN_WCFG;
                xflags = 3'b011;
            end
            KIND_WFAD: begin
                funct7 = FN_WFAD;
                xflags = 3'b011;
                rd_f   = rd;
            end
            KIND_MATRIX: begin
                funct7 = FN_MATRIX;
                xflags = 3'b011;
            end
            KIND_WACC: begin
                funct7 = FN_WACC;
                rs2_f  = pe;
                xflags = 3'b010;
                rd_f   = {2'b00, row};
            end
            KIND_RACC: begin
                funct7 = FN_RACC;
                rs2_f  = pe;
                rs1_f  = accreg_id(row, en_flag);
                xflags = 3'b100;
            end
            KIND_RELU: begin
                funct7 = FN_RELU;
                rs2_f  = accreg_id(row, en_flag);
                xflags = 3'b010;
            end
            default: ;
        endcase
        instr = {funct7, rs2_f, rs1_f, xflags, rd_f, OPCODE};
    end

endmodule

// File: rtl/hwpe_cmd_sequencer.sv
// Emits the HWPE command stream for one convolution layer over a
// registered ready/valid port.
//
//   state     | meaning
//   ----------+------------------------------------------------------
//   ST_IDLE   | waiting for start; the start cycle emits the reset beat
//   ST_RST    | reset command (only ever seen as the start-cycle alias)
//   ST_WCFG   | layer config word (cfg0/cfg1)
//   ST_WFAD   | feature base addresses, two per beat
//   ST_WACC   | accumulator writes, row outer / pe inner
//   ST_MATRIX | matrix launch (vrs1/vrs2)
//   ST_DRAIN  | per-tile racc or relu drain, k outer / w / h inner
//   ST_FIN    | wait for the last beat to leave, then pulse done
//
// The state and loop counters always describe the next beat to load;
// a beat is loaded whenever the output register is empty or draining.
module hwpe_cmd_sequencer
    import hwpe_cmd_pkg::*;
#(
    parameter int unsigned ROWS      = 8,
    parameter int unsigned PES       = 16,
    parameter int unsigned NUM_FADDR = 8,
    parameter logic [6:0]  OPCODE    = 7'b0001011
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    input  logic [31:0]               cfg0,
    input  logic [31:0]               cfg1,
    input  logic [31:0]               cfg_vrs1,
    input  logic [31:0]               cfg_vrs2,
    input  logic [32*NUM_FADDR-1:0]   cfg_base_addr,
    input  logic [9:0]                cfg_k_count,
    input  logic [1:0]                cfg_mode,
    input  logic [31:0]               cfg_relu_addr,
    output logic                      cmd_valid,
    input  logic                      cmd_ready,
    output logic [95:0]               cmd_data,
    output logic                      busy,
    output logic                      done,
    output logic [31:0]               beat_cnt
);

    localparam int unsigned     FA_W      = $clog2(NUM_FADDR);
    localparam logic [2:0]      ROW_LAST  = 3'(ROWS - 1);
    localparam logic [4:0]      PE_LAST   = 5'(PES - 1);
    localparam logic [FA_W-1:0] FAD_LAST  = FA_W'(NUM_FADDR - 2);
    localparam logic [FA_W-1:0] FAD_STEP  = FA_W'(2);
    localparam logic [FA_W-1:0] FAD_ONE   = FA_W'(1);

    state_e            state_q, state_d, cur_state;
    logic [2:0]        row_q, row_d;
    logic [4:0]        pe_q, pe_d;
    logic [FA_W-1:0]   fad_q, fad_d;
    logic [9:0]        k_q, k_d;
    logic [15:0]       w_q, w_d;
    logic [15:0]       h_q, h_d;

    logic [31:0]       cfg0_q, cfg0_d;
    logic [31:0]       cfg1_q, cfg1_d;
    logic [31:0]       vrs1_q, vrs1_d;
    logic [31:0]       vrs2_q, vrs2_d;
    logic [31:0]       relu_addr_q, relu_addr_d;
    logic [31:0]       base_q [NUM_FADDR];
    logic [31:0]       base_d [NUM_FADDR];
    logic [9:0]        k_cnt_q, k_cnt_d;
    logic [1:0]        mode_q, mode_d;

    logic              cmd_valid_q, cmd_valid_d;
    logic [95:0]       cmd_data_q, cmd_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [31:0]       beat_cnt_q, beat_cnt_d;

    logic              start_acc, xfer, slot_free, load;
    logic              drain_relu, skip_drain;
    logic              k_last, w_last, h_last, final_tile, tile_last;
    logic [15:0]       w_cnt, h_cnt;

    cmd_kind_e         enc_kind;
    logic [4:0]        enc_rd;
    logic              enc_en;
    logic [31:0]       enc_instr;
    logic [31:0]       rs1_val, rs2_val;

    assign start_acc  = start && (state_q == ST_IDLE) && !abort;
    assign cur_state  = start_acc ? ST_RST : state_q;
    assign xfer       = cmd_valid_q && cmd_ready;
    assign slot_free  = !cmd_valid_q || cmd_ready;
    assign load       = slot_free && (cur_state != ST_IDLE) && (cur_state != ST_FIN);

    assign w_cnt      = vrs1_q[31:16];
    assign h_cnt      = vrs1_q[15:0];
    assign drain_relu = (mode_q == MODE_RELU);
    assign skip_drain = (mode_q == MODE_ACC_ONLY) || (k_cnt_q == '0) ||
                        (w_cnt == '0) || (h_cnt == '0);
    assign k_last     = (k_q == k_cnt_q - 10'd1);
    assign w_last     = (w_q == w_cnt - 16'd1);
    assign h_last     = (h_q == h_cnt - 16'd1);
    assign final_tile = k_last && w_last && h_last;
    assign tile_last  = drain_relu ? (row_q == ROW_LAST)
                                   : ((row_q == ROW_LAST) && (pe_q == PE_LAST));

    // Next state, loop counters and the config snapshot taken on start.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        pe_d        = pe_q;
        fad_d       = fad_q;
        k_d         = k_q;
        w_d         = w_q;
        h_d         = h_q;
        cfg0_d      = cfg0_q;
        cfg1_d      = cfg1_q;
        vrs1_d      = vrs1_q;
        vrs2_d      = vrs2_q;
        relu_addr_d = relu_addr_q;
        base_d      = base_q;
        k_cnt_d     = k_cnt_q;
        mode_d      = mode_q;

        if (start_acc) begin
            cfg0_d      = cfg0;
            cfg1_d      = cfg1;
            vrs1_d      = cfg_vrs1;
            vrs2_d      = cfg_vrs2;
            relu_addr_d = cfg_relu_addr;
            k_cnt_d     = cfg_k_count;
            mode_d      = (cfg_mode == MODE_RESERVED) ? MODE_READACC : cfg_mode;
            for (int i = 0; i < NUM_FADDR; i++) begin
                base_d[i] = cfg_base_addr[32*i +: 32];
            end
            row_d = '0;
            pe_d  = '0;
            fad_d = '0;
            k_d   = '0;
            w_d   = '0;
            h_d   = '0;
        end

        if (load) begin
            case (cur_state)
                ST_RST:  state_d = ST_WCFG;
                ST_WCFG: state_d = ST_WFAD;
                ST_WFAD: begin
                    if (fad_q == FAD_LAST) begin
                        fad_d   = '0;
                        state_d = ST_WACC;
                    end else begin
                        fad_d = fad_q + FAD_STEP;
                    end
                end
                ST_WACC: begin
                    if (pe_q == PE_LAST) begin
                        pe_d = '0;
                        if (row_q == ROW_LAST) begin
                            row_d   = '0;
                            state_d = ST_MATRIX;
                        end else begin
                            row_d = row_q + 3'd1;
                        end
                    end else begin
                        pe_d = pe_q + 5'd1;
                    end
                end
                ST_MATRIX: state_d = skip_drain ? ST_FIN : ST_DRAIN;
                ST_DRAIN: begin
                    if (drain_relu) begin
                        row_d = row_q + 3'd1;
                    end else if (pe_q == PE_LAST) begin
                        pe_d  = '0;
                        row_d = row_q + 3'd1;
                    end else begin
                        pe_d = pe_q + 5'd1;
                    end
                    if (tile_last) begin
                        row_d = '0;
                        pe_d  = '0;
                        h_d   = h_last ? '0 : h_q + 16'd1;
                        if (h_last) begin
                            w_d = w_last ? '0 : w_q + 16'd1;
                        end
                        if (h_last && w_last) begin
                            k_d = k_last ? '0 : k_q + 10'd1;
                        end
                        if (final_tile) begin
                            state_d = ST_FIN;
                        end
                    end
                end
                default: ;
            endcase
        end else if ((state_q == ST_FIN) && slot_free) begin
            state_d = ST_IDLE;
        end

        if (abort) begin
            state_d = ST_IDLE;
        end
    end

    // Command kind and operand words for the beat being loaded.
    always_comb begin
        enc_kind = KIND_RESET;
        rs1_val  = '0;
        rs2_val  = '0;
        enc_rd   = 5'(fad_q);
        enc_en   = (cur_state == ST_DRAIN) && tile_last && !final_tile;
        case (cur_state)
            ST_WCFG: begin
                enc_kind = KIND_WCFG;
                rs1_val  = cfg0_q;
                rs2_val  = cfg1_q;
            end
            ST_WFAD: begin
                enc_kind = KIND_WFAD;
                rs1_val  = base_q[fad_q];
                rs2_val  = base_q[fad_q | FAD_ONE];
            end
            ST_WACC: enc_kind = KIND_WACC;
            ST_MATRIX: begin
                enc_kind = KIND_MATRIX;
                rs1_val  = vrs1_q;
                rs2_val  = vrs2_q;
            end
            ST_DRAIN: begin
                if (drain_relu) begin
                    enc_kind = KIND_RELU;
                    rs1_val  = relu_addr_q;
                end else begin
                    enc_kind = KIND_RACC;
                end
            end
            default: ;
        endcase
    end

    hwpe_instr_enc #(
        .OPCODE  (OPCODE)
    ) u_enc (
        .kind    (enc_kind),
        .row     (row_q),
        .pe      (pe_q),
        .rd      (enc_rd),
        .en_flag (enc_en),
        .instr   (enc_instr)
    );

    // Output register, busy/done flags and the saturating beat counter.
    always_comb begin
        cmd_valid_d = cmd_valid_q;
        cmd_data_d  = cmd_data_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        beat_cnt_d  = beat_cnt_q;

        if (load) begin
            cmd_valid_d = 1'b1;
            cmd_data_d  = {enc_instr, rs1_val, rs2_val};
        end else if (xfer) begin
            cmd_valid_d = 1'b0;
        end

        if (start_acc) begin
            busy_d     = 1'b1;
            beat_cnt_d = '0;
        end else if (xfer && (beat_cnt_q != '1)) begin
            beat_cnt_d = beat_cnt_q + 32'd1;
        end

        if ((state_q == ST_FIN) && slot_free) begin
            busy_d = 1'b0;
            done_d = 1'b1;
        end

        if (abort) begin
            cmd_valid_d = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b0;
            beat_cnt_d  = beat_cnt_q;
        end
    end

    // State register: FSM state, loop counters and config snapshot.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            row_q       <= '0;
            pe_q        <= '0;
            fad_q       <= '0;
            k_q         <= '0;
            w_q         <= '0;
            h_q         <= '0;
            cfg0_q      <= '0;
            cfg1_q      <= '0;
            vrs1_q      <= '0;
            vrs2_q      <= '0;
            relu_addr_q <= '0;
            k_cnt_q     <= '0;
            mode_q      <= MODE_READACC;
            for (int i = 0; i < NUM_FADDR; i++) begin
                base_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            pe_q        <= pe_d;
            fad_q       <= fad_d;
            k_q         <= k_d;
            w_q         <= w_d;
            h_q         <= h_d;
            cfg0_q      <= cfg0_d;
            cfg1_q      <= cfg1_d;
            vrs1_q      <= vrs1_d;
            vrs2_q      <= vrs2_d;
            relu_addr_q <= relu_addr_d;
            k_cnt_q     <= k_cnt_d;
            mode_q      <= mode_d;
            base_q      <= base_d;
        end
    end

    // Output flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_valid_q <= 1'b0;
            cmd_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            beat_cnt_q  <= '0;
        end else begin
            cmd_valid_q <= cmd_valid_d;
            cmd_data_q  <= cmd_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_data  = cmd_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign beat_cnt  = beat_cnt_q;

endmodule

// File: tb/tb_hwpe_cmd_sequencer.sv
// Directed bench for hwpe_cmd_sequencer with hand-computed beat values.
module tb_hwpe_cmd_sequencer;

    localparam int NUM_FADDR = 8;
    localparam logic [31:0] CFG0  = 32'hA0A0_0010;
    localparam logic [31:0] CFG1  = 32'h1234_5678;
    localparam logic [31:0] VRS2  = 32'h0002_0001;
    localparam logic [31:0] RELUA = 32'hCAFE_0000;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    start;
    logic                    abort;
    logic [31:0]             cfg0, cfg1, cfg_vrs1, cfg_vrs2, cfg_relu_addr;
    logic [32*NUM_FADDR-1:0] cfg_base_addr;
    logic [9:0]              cfg_k_count;
    logic [1:0]              cfg_mode;
    logic                    cmd_valid;
    logic                    cmd_ready = 1'b1;
    logic [95:0]             cmd_data;
    logic                    busy, done;
    logic [31:0]             beat_cnt;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [95:0] beats [$];
    logic [95:0] ref_beats [$];
    int          done_cnt     = 0;
    int          stall_viol   = 0;
    int          stall_cycles = 0;
    bit          prev_stalled = 1'b0;
    logic [95:0] prev_data    = '0;
    bit          stall_en     = 1'b0;

    always #5 clk = ~clk;

    hwpe_cmd_sequencer #(
        .ROWS(8), .PES(16), .NUM_FADDR(NUM_FADDR), .OPCODE(7'b0001011)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg0(cfg0), .cfg1(cfg1), .cfg_vrs1(cfg_vrs1), .cfg_vrs2(cfg_vrs2),
        .cfg_base_addr(cfg_base_addr), .cfg_k_count(cfg_k_count),
        .cfg_mode(cfg_mode), .cfg_relu_addr(cfg_relu_addr),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .busy(busy), .done(done), .beat_cnt(beat_cnt)
    );

    // Downstream ready: always 1, or a coin flip per cycle when stalling.
    always @(posedge clk) begin
        #1;
        cmd_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Beat capture, done counting and stall-stability monitoring.
    always @(negedge clk) begin
        if (rst) begin
            prev_stalled = 1'b0;
        end else begin
            if (prev_stalled && (!cmd_valid || cmd_data !== prev_data)) stall_viol++;
            if (cmd_valid && cmd_ready && !abort) beats.push_back(cmd_data);
            if (done) done_cnt++;
            prev_stalled = cmd_valid && !cmd_ready && !abort;
            if (prev_stalled) stall_cycles++;
            prev_data = cmd_data;
        end
    end

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [95:0] beat_at(input int idx);
        if (idx >= 0 && idx < beats.size()) return beats[idx];
        return '0;
    endfunction

    task automatic run_layer(input logic [9:0] k, input logic [15:0] w, input logic [15:0] h,
                             input logic [1:0] mode, input bit poke,
                             output int base, output int nbeats);
        int d0;
        bit seen;
        cfg_k_count = k;
        cfg_vrs1    = {w, h};
        cfg_mode    = mode;
        base        = beats.size();
        d0          = done_cnt;
        start       = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("valid_after_start", cmd_valid, 1'b1);
        check("busy_after_start", busy, 1'b1);
        seen = 1'b0;
        for (int c = 0; c < 5000 && !seen; c++) begin
            if (poke && c == 10) begin
                cfg_mode = 2'd1;
                cfg_vrs1 = 32'h0001_0005;
                start    = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        check("done_seen", seen, 1'b1);
        check("busy_after_done", busy, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("done_pulses", done_cnt - d0, 1);
        nbeats = beats.size() - base;
    endtask

    initial begin
        int b, n, d0, mism, s0, sc0;
        bit reached;

        rst = 1'b1; start = 1'b0; abort = 1'b0;
        cfg0 = CFG0; cfg1 = CFG1; cfg_vrs2 = VRS2; cfg_relu_addr = RELUA;
        cfg_vrs1 = 32'h0001_0001; cfg_k_count = 10'd1; cfg_mode = 2'd0;
        for (int i = 0; i < NUM_FADDR; i++)
            cfg_base_addr[32*i +: 32] = 32'h1000_0000 + 32'(i) * 32'h100;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_valid", cmd_valid, 1'b0);
        check("rst_data", cmd_data, 96'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_beat_cnt", beat_cnt, 32'd0);
        @(posedge clk); #1;

        // Single tile, readacc.
        run_layer(10'd1, 16'd1, 16'd1, 2'd0, 1'b0, b, n);
        check("t1_total", n, 263);
        check("t1_beat_cnt", beat_cnt, 32'd263);
        check("t1_b0", beat_at(b), {32'h8000000B, 32'h0, 32'h0});
        check("t1_b1", beat_at(b+1), {32'h0400300B, CFG0, CFG1});
        check("t1_b2", beat_at(b+2), {32'h0200300B, 32'h1000_0000, 32'h1000_0100});
        check("t1_b3_instr", beat_at(b+3) >> 64, 96'h0200310B);
        check("t1_b5", beat_at(b+5), {32'h0200330B, 32'h1000_0600, 32'h1000_0700});
        check("t1_wacc_first", beat_at(b+6), {32'h1000200B, 32'h0, 32'h0});
        check("t1_wacc_r1p3", beat_at(b+25) >> 64, 96'h1030208B);
        check("t1_wacc_last", beat_at(b+133) >> 64, 96'h10F0238B);
        check("t1_matrix", beat_at(b+134), {32'h0800300B, 32'h0001_0001, VRS2});
        check("t1_racc_first", beat_at(b+135), {32'h2000400B, 32'h0, 32'h0});
        check("t1_last", beat_at(b+262) >> 64, 96'h20F3C00B);

        // Two tiles, readacc, with a start pulse mid-run that must be ignored.
        run_layer(10'd1, 16'd1, 16'd2, 2'd0, 1'b1, b, n);
        check("t2_total", n, 391);
        check("t2_matrix_rs1", beat_at(b+134), {32'h0800300B, 32'h0001_0002, VRS2});
        check("t2_tile0_last", beat_at(b+262) >> 64, 96'h20FBC00B);
        check("t2_tile1_first", beat_at(b+263) >> 64, 96'h2000400B);
        check("t2_last", beat_at(b+390) >> 64, 96'h20F3C00B);
        for (int i = 0; i < n; i++) ref_beats.push_back(beat_at(b+i));

        // Relu drain, two tiles.
        run_layer(10'd1, 16'd1, 16'd2, 2'd1, 1'b0, b, n);
        check("t3_total", n, 151);
        check("t3_relu_first", beat_at(b+135), {32'h4000200B, RELUA, 32'h0});
        check("t3_relu_en", beat_at(b+142), {32'h4170200B, RELUA, 32'h0});
        check("t3_last", beat_at(b+150), {32'h4070200B, RELUA, 32'h0});

        // Random backpressure must not change the beat sequence.
        s0 = stall_viol; sc0 = stall_cycles;
        stall_en = 1'b1;
        run_layer(10'd1, 16'd1, 16'd2, 2'd0, 1'b0, b, n);
        stall_en = 1'b0;
        check("t4_total", n, 391);
        mism = 0;
        for (int i = 0; i < 391; i++)
            if (beat_at(b+i) !== ((i < ref_beats.size()) ? ref_beats[i] : 96'd0)) mism++;
        check("t4_seq_mismatches", mism, 0);
        check("t4_stall_hold", stall_viol - s0, 0);
        check("t4_stalls_seen", (stall_cycles - sc0) > 0, 1'b1);
        @(posedge clk); #1;

        // Drain skipped: accumulate-only mode, then zero width count.
        run_layer(10'd1, 16'd1, 16'd1, 2'd2, 1'b0, b, n);
        check("t5_mode2_total", n, 135);
        check("t5_mode2_last", beat_at(b+134) >> 64, 96'h0800300B);
        run_layer(10'd1, 16'd0, 16'd1, 2'd0, 1'b0, b, n);
        check("t5_w0_total", n, 135);

        // Abort after 40 accepted beats.
        cfg_k_count = 10'd1; cfg_vrs1 = 32'h0001_0001; cfg_mode = 2'd0;
        b = beats.size(); d0 = done_cnt;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        reached = 1'b0;
        for (int c = 0; c < 500 && !reached; c++) begin
            if (beat_cnt == 32'd40) reached = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        check("t6_reach_40", reached, 1'b1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("t6_valid", cmd_valid, 1'b0);
        check("t6_busy", busy, 1'b0);
        check("t6_beat_cnt", beat_cnt, 32'd40);
        repeat (4) @(posedge clk);
        #1;
        check("t6_no_done", done_cnt - d0, 0);
        check("t6_beat_cnt_hold", beat_cnt, 32'd40);
        check("t6_beats_seen", beats.size() - b, 40);
        run_layer(10'd1, 16'd1, 16'd1, 2'd0, 1'b0, b, n);
        check("t6_replay_first", beat_at(b), {32'h8000000B, 32'h0, 32'h0});
        check("t6_replay_total", n, 263);

        // Reset mid-run.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("t7_valid", cmd_valid, 1'b0);
        check("t7_data", cmd_data, 96'd0);
        check("t7_busy", busy, 1'b0);
        check("t7_beat_cnt", beat_cnt, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        run_layer(10'd1, 16'd1, 16'd1, 2'd0, 1'b0, b, n);
        check("t7_after_total", n, 263);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
